ps2_key_event_queue: RTL and testbench
======================================

// Module: ps2_key_event_queue
// PURPOSE
//  Parametrised PS/2 scan-code set-2 decoder: consumes bytes from the PS/2 byte receiver,
//  assembles E0/F0 sequences, maintains a 512-bit key_down map, and queues make/break events
//  in a FIFO for the game logic. Adds typematic-repeat suppression, rollover limit, sequence
//  timeout, Pause-sequence skipping and an overflow flag.
// PARAMETERS
//  FIFO_DEPTH       8       event FIFO entries; power of 2, >=2
//  SUPPRESS_REPEAT  1       1: make of an already-down key produces no event
//  MAX_DOWN         6       max simultaneously held keys; 0 = unlimited
//  TIMEOUT_CYC      100000  clk cycles allowed between bytes of one sequence
// PORTS
//  clk           in   1    clock
//  rst           in   1    reset, asynchronous, active-high
//  byte_valid    in   1    one-cycle strobe, byte_data valid
//  byte_data     in   8    received byte
//  byte_err      in   1    one-cycle strobe, receiver parity/framing error
//  flush         in   1    sync: empty FIFO, clear key_down, return to IDLE
//  key_down      out  512  bit {ext,scan} set while key held
//  down_count    out  4    number of bits set in key_down (saturates at 15)
//  evt_valid     out  1    FIFO non-empty
//  evt_ready     in   1    consumer pop; pop happens when evt_valid & evt_ready
//  evt_code      out  9    {ext,scan} of head event
//  evt_break     out  1    head event is a release
//  fifo_ovf      out  1    sticky: event dropped on full FIFO; cleared by flush/rst
//  rollover      out  1    one-cycle pulse: make dropped due to MAX_DOWN
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state IDLE, flags clear, timeout counter 0.
//  FSM (advances only on byte_valid): IDLE: E0->EXT, F0->BRK, E1->PAUSE(skip=7),
//   AA->clear key_down/down_count, stay IDLE; FA/FE/EE/00/FF ignored; other->complete(ext=0,brk=0).
//   EXT: F0->EXT_BRK; E0/E1/F0-like prefixes->IDLE (discard); other->complete(ext=1,brk=0).
//   BRK: other->complete(0,1). EXT_BRK: other->complete(1,1). Prefix byte in BRK/EXT_BRK->IDLE.
//   PAUSE: each byte decrements skip; at skip==1 byte -> IDLE; no event, no map change.
//  Timeout: counter clears on every byte_valid; in any state but IDLE reaching TIMEOUT_CYC -> IDLE.
//  byte_err in any state -> IDLE, partial sequence discarded, no event.
//  complete(ext,brk), code={ext,scan}:
//   make, bit set: SUPPRESS_REPEAT=1 -> nothing; =0 -> push make event, map unchanged.
//   make, bit clear: if MAX_DOWN!=0 && down_count==MAX_DOWN -> rollover pulse, nothing else;
//    else set bit, down_count+1, push make event.
//   break, bit set: clear bit, down_count-1, push break event. break, bit clear: ignored.
//  Latency: key_down/down_count/evt_valid update at the edge sampling the final byte (1 cycle).
//  FIFO: first-word-fall-through; evt_code/evt_break = head entry, undefined-but-stable when empty.
//   Push on full: event dropped, fifo_ovf<=1, key_down still updated. Push and pop in same
//   cycle when full: pop then push, both succeed, no overflow. Pointers wrap modulo FIFO_DEPTH.
//  flush has priority over a same-cycle byte_valid/pop; that byte is discarded.
//  rst mid-sequence: everything returns to reset state immediately.
// TESTING
//  bytes 1C -> key_down[0x01C]=1, event {0x01C,make}, down_count=1, evt_valid next cycle.
//  E0 F0 74 after E0 74 -> bit 0x174 set then cleared; events make,break for 0x174 in order.
//  1C 1C 1C (repeat), SUPPRESS_REPEAT=1 -> one event; then F0 1C -> break event, count=0.
//  7 distinct makes, MAX_DOWN=6 -> 6 events, rollover pulse on 7th, down_count=6.
//  9 makes with evt_ready=0, FIFO_DEPTH=8 -> 8 queued, fifo_ovf=1, all 9 bits set; flush clears all.
//  E0 then byte_err or TIMEOUT_CYC idle, then 1C -> only {0x01C,make}; E1 14 77 E1 F0 14 F0 77 -> none.

Source files
------------

// File: rtl/ps2_key_event_queue.sv
// PS/2 scan-code set-2 decoder with a key-down map and a make/break event FIFO.
module ps2_key_event_queue #(
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned SUPPRESS_REPEAT = 1,
    parameter int unsigned MAX_DOWN        = 6,
    parameter int unsigned TIMEOUT_CYC     = 100000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         byte_valid,
    input  logic [7:0]   byte_data,
    input  logic         byte_err,
    input  logic         flush,
    output logic [511:0] key_down,
    output logic [3:0]   down_count,
    output logic         evt_valid,
    input  logic         evt_ready,
    output logic [8:0]   evt_code,
    output logic         evt_break,
    output logic         fifo_ovf,
    output logic         rollover
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} state_t;

    state_t        state, state_nxt;
    logic [2:0]    skip;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          is_prefix, is_ignored, byte_ok;
    logic          cplt, cplt_ext, cplt_brk, aa_clear, pause_load;
    logic [8:0]    code_c;
    logic          hit, push, set_bit, clr_bit, roll;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic          pop, full, push_ok, drop;
    logic [9:0]    mem [FIFO_DEPTH];
    logic [9:0]    head;

    assign is_prefix  = (byte_data == 8'hE0) || (byte_data == 8'hE1) || (byte_data == 8'hF0);
    assign is_ignored = (byte_data == 8'hFA) || (byte_data == 8'hFE) || (byte_data == 8'hEE) ||
                        (byte_data == 8'h00) || (byte_data == 8'hFF);
    assign byte_ok    = byte_valid && !byte_err;
    assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT_CYC));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        state <= S_IDLE;
        else if (flush) state <= S_IDLE;
        else            state <= state_nxt;
    end

    // Next-state: advances on bytes, aborts on receiver error or inter-byte timeout
    always_comb begin
        state_nxt = state;
        if (byte_err) begin
            state_nxt = S_IDLE;
        end else if (byte_valid) begin
            case (state)
                S_IDLE: begin
                    if (byte_data == 8'hE0)      state_nxt = S_EXT;
                    else if (byte_data == 8'hF0) state_nxt = S_BRK;
                    else if (byte_data == 8'hE1) state_nxt = S_PAUSE;
                end
                S_EXT:     state_nxt = (byte_data == 8'hF0) ? S_EXT_BRK : S_IDLE;
                S_BRK:     state_nxt = S_IDLE;
                S_EXT_BRK: state_nxt = S_IDLE;
                S_PAUSE:   state_nxt = (skip == 3'd1) ? S_IDLE : S_PAUSE;
                default:   state_nxt = S_IDLE;
            endcase
        end else if (state != S_IDLE && tmo_hit) begin
            state_nxt = S_IDLE;
        end
    end

    // FSM outputs: sequence completion, power-on-test clear, pause skip load
    always_comb begin
        cplt       = 1'b0;
        cplt_ext   = 1'b0;
        cplt_brk   = 1'b0;
        aa_clear   = 1'b0;
        pause_load = 1'b0;
        if (byte_ok) begin
            case (state)
                S_IDLE: begin
                    if (byte_data == 8'hE1)                  pause_load = 1'b1;
                    else if (byte_data == 8'hAA)             aa_clear   = 1'b1;
                    else if (!is_prefix && !is_ignored)      cplt       = 1'b1;
                end
                S_EXT: begin
                    cplt     = !is_prefix;
                    cplt_ext = 1'b1;
                end
                S_BRK: begin
                    cplt     = !is_prefix;
                    cplt_brk = 1'b1;
                end
                S_EXT_BRK: begin
                    cplt     = !is_prefix;
                    cplt_ext = 1'b1;
                    cplt_brk = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Pause-sequence byte counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   skip <= 3'd0;
        else if (flush)                            skip <= 3'd0;
        else if (pause_load)                       skip <= 3'd7;
        else if (state == S_PAUSE && byte_ok)      skip <= skip - 3'd1;
    end

    // Inter-byte timeout counter, idle while no sequence is in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          tmo_cnt <= '0;
        else if (flush || byte_valid || state == S_IDLE)  tmo_cnt <= '0;
        else if (!tmo_hit)                                tmo_cnt <= tmo_cnt + TW'(1);
    end

    assign code_c = {cplt_ext, byte_data};
    assign hit    = key_down[code_c];

    // Resolve a completed code against the key map: repeat, rollover, make, break
    always_comb begin
        push    = 1'b0;
        set_bit = 1'b0;
        clr_bit = 1'b0;
        roll    = 1'b0;
        if (cplt) begin
            if (!cplt_brk) begin
                if (hit) begin
                    push = (SUPPRESS_REPEAT == 0);
                end else if (MAX_DOWN != 0 && down_count == 4'(MAX_DOWN)) begin
                    roll = 1'b1;
                end else begin
                    set_bit = 1'b1;
                    push    = 1'b1;
                end
            end else if (hit) begin
                clr_bit = 1'b1;
                push    = 1'b1;
            end
        end
    end

    // Key-down map and saturating held-key count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_down   <= '0;
            down_count <= 4'd0;
        end else if (flush || aa_clear) begin
            key_down   <= '0;
            down_count <= 4'd0;
        end else if (set_bit) begin
            key_down[code_c] <= 1'b1;
            down_count       <= (down_count == 4'd15) ? 4'd15 : down_count + 4'd1;
        end else if (clr_bit) begin
            key_down[code_c] <= 1'b0;
            down_count       <= (down_count == 4'd0) ? 4'd0 : down_count - 4'd1;
        end
    end

    assign pop     = evt_valid && evt_ready;
    assign full    = (fifo_cnt == CW'(FIFO_DEPTH));
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    // FIFO pointers and occupancy; a pop frees the slot for a same-cycle push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= {cplt_brk, code_c};
    end

    // Sticky overflow flag and rollover pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_ovf <= 1'b0;
            rollover <= 1'b0;
        end else if (flush) begin
            fifo_ovf <= 1'b0;
            rollover <= 1'b0;
        end else begin
            if (drop) fifo_ovf <= 1'b1;
            rollover <= roll;
        end
    end

    assign head      = mem[rd_ptr];
    assign evt_valid = (fifo_cnt != '0);
    assign evt_code  = head[8:0];
    assign evt_break = head[9];

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed self-checking bench for ps2_key_event_queue.
module tb_ps2_key_event_queue;

    logic         clk = 1'b0;
    logic         rst;
    logic         byte_valid;
    logic [7:0]   byte_data;
    logic         byte_err;
    logic         flush;
    logic [511:0] key_down;
    logic [3:0]   down_count;
    logic         evt_valid;
    logic         evt_ready;
    logic [8:0]   evt_code;
    logic         evt_break;
    logic         fifo_ovf;
    logic         rollover;

    int checks = 0;
    int errors = 0;

    ps2_key_event_queue #(
        .FIFO_DEPTH(8), .SUPPRESS_REPEAT(1), .MAX_DOWN(6), .TIMEOUT_CYC(50)
    ) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_err(byte_err), .flush(flush), .key_down(key_down), .down_count(down_count),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_break(evt_break), .fifo_ovf(fifo_ovf), .rollover(rollover)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pop_one();
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; byte_err = 1'b0;
        flush = 1'b0; evt_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (key_down !== '0 || down_count !== 4'd0 || evt_valid !== 1'b0 ||
            fifo_ovf !== 1'b0 || rollover !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got cnt=%0d valid=%b ovf=%b roll=%b map_nz=%b exp all zero",
                     down_count, evt_valid, fifo_ovf, rollover, |key_down);
        end
        rst = 1'b0;
    endtask

    task automatic test_make();
        send(8'h1C);
        checks++;
        if (key_down[9'h01C] !== 1'b1 || down_count !== 4'd1) begin
            errors++;
            $display("FAIL make_map: got bit=%b cnt=%0d exp bit=1 cnt=1", key_down[9'h01C], down_count);
        end
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 9'h01C || evt_break !== 1'b0) begin
            errors++;
            $display("FAIL make_event: got v=%b code=%h brk=%b exp v=1 code=01c brk=0",
                     evt_valid, evt_code, evt_break);
        end
        pop_one();
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL make_pop_empty: got valid=%b exp 0", evt_valid);
        end
    endtask

    task automatic test_ext();
        logic [9:0] exp_q [2];
        exp_q[0] = {1'b0, 9'h174};
        exp_q[1] = {1'b1, 9'h174};
        send(8'hE0); send(8'h74);
        checks++;
        if (key_down[9'h174] !== 1'b1 || down_count !== 4'd2) begin
            errors++;
            $display("FAIL ext_make_map: got bit=%b cnt=%0d exp bit=1 cnt=2", key_down[9'h174], down_count);
        end
        send(8'hE0); send(8'hF0); send(8'h74);
        checks++;
        if (key_down[9'h174] !== 1'b0 || down_count !== 4'd1) begin
            errors++;
            $display("FAIL ext_break_map: got bit=%b cnt=%0d exp bit=0 cnt=1", key_down[9'h174], down_count);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (evt_valid !== 1'b1 || {evt_break, evt_code} !== exp_q[i]) begin
                errors++;
                $display("FAIL ext_event%0d: got v=%b {brk,code}=%h exp v=1 %h",
                         i, evt_valid, {evt_break, evt_code}, exp_q[i]);
            end
            pop_one();
        end
    endtask

    task automatic test_repeat();
        do_flush();
        send(8'h1C); send(8'h1C); send(8'h1C);
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 9'h01C || evt_break !== 1'b0 || down_count !== 4'd1) begin
            errors++;
            $display("FAIL repeat_first: got v=%b code=%h brk=%b cnt=%0d exp 1 01c 0 1",
                     evt_valid, evt_code, evt_break, down_count);
        end
        pop_one();
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL repeat_suppressed: got valid=%b exp 0", evt_valid);
        end
        send(8'hF0); send(8'h1C);
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 9'h01C || evt_break !== 1'b1 || down_count !== 4'd0) begin
            errors++;
            $display("FAIL repeat_break: got v=%b code=%h brk=%b cnt=%0d exp 1 01c 1 0",
                     evt_valid, evt_code, evt_break, down_count);
        end
        pop_one();
    endtask

    task automatic test_rollover();
        logic [7:0] keys [7];
        keys = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C};
        do_flush();
        for (int i = 0; i < 6; i++) send(keys[i]);
        checks++;
        if (rollover !== 1'b0 || down_count !== 4'd6) begin
            errors++;
            $display("FAIL rollover_pre: got roll=%b cnt=%0d exp 0 6", rollover, down_count);
        end
        send(keys[6]);
        checks++;
        if (rollover !== 1'b1 || down_count !== 4'd6 || key_down[9'h03C] !== 1'b0) begin
            errors++;
            $display("FAIL rollover_pulse: got roll=%b cnt=%0d bit=%b exp 1 6 0",
                     rollover, down_count, key_down[9'h03C]);
        end
        @(negedge clk);
        checks++;
        if (rollover !== 1'b0) begin
            errors++;
            $display("FAIL rollover_one_cycle: got %b exp 0", rollover);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_code !== {1'b0, keys[i]} || evt_break !== 1'b0) begin
                errors++;
                $display("FAIL rollover_evt%0d: got v=%b code=%h brk=%b exp 1 %h 0",
                         i, evt_valid, evt_code, evt_break, {1'b0, keys[i]});
            end
            pop_one();
        end
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL rollover_only6: got valid=%b exp 0", evt_valid);
        end
    endtask

    task automatic test_overflow();
        logic [9:0] exp_q [8];
        exp_q = '{10'h01D, 10'h024, 10'h02D, 10'h02C, 10'h035, 10'h215, 10'h21D, 10'h224};
        do_flush();
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C); send(8'h35);
        send(8'hF0); send(8'h15); send(8'hF0); send(8'h1D);
        checks++;
        if (evt_valid !== 1'b1 || fifo_ovf !== 1'b0 || down_count !== 4'd4) begin
            errors++;
            $display("FAIL ovf_full: got v=%b ovf=%b cnt=%0d exp 1 0 4", evt_valid, fifo_ovf, down_count);
        end
        send(8'hF0);
        @(negedge clk);
        byte_valid = 1'b1; byte_data = 8'h24; evt_ready = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0; evt_ready = 1'b0;
        checks++;
        if (fifo_ovf !== 1'b0 || down_count !== 4'd3) begin
            errors++;
            $display("FAIL ovf_pop_push_full: got ovf=%b cnt=%0d exp 0 3", fifo_ovf, down_count);
        end
        send(8'h3C);
        checks++;
        if (fifo_ovf !== 1'b1 || key_down[9'h03C] !== 1'b1 || down_count !== 4'd4) begin
            errors++;
            $display("FAIL ovf_drop: got ovf=%b bit=%b cnt=%0d exp 1 1 4",
                     fifo_ovf, key_down[9'h03C], down_count);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (evt_valid !== 1'b1 || {evt_break, evt_code} !== exp_q[i]) begin
                errors++;
                $display("FAIL ovf_evt%0d: got v=%b {brk,code}=%h exp v=1 %h",
                         i, evt_valid, {evt_break, evt_code}, exp_q[i]);
            end
            pop_one();
        end
        checks++;
        if (evt_valid !== 1'b0 || fifo_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drained: got v=%b ovf=%b exp 0 1", evt_valid, fifo_ovf);
        end
        @(negedge clk);
        flush = 1'b1; byte_valid = 1'b1; byte_data = 8'h1C;
        @(negedge clk);
        flush = 1'b0; byte_valid = 1'b0;
        checks++;
        if (key_down !== '0 || down_count !== 4'd0 || fifo_ovf !== 1'b0 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: got map_nz=%b cnt=%0d ovf=%b v=%b exp 0 0 0 0",
                     |key_down, down_count, fifo_ovf, evt_valid);
        end
    endtask

    task automatic test_abort();
        do_flush();
        send(8'hE0);
        @(negedge clk); byte_err = 1'b1;
        @(negedge clk); byte_err = 1'b0;
        send(8'h1C);
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 9'h01C || evt_break !== 1'b0 || key_down[9'h11C] !== 1'b0) begin
            errors++;
            $display("FAIL err_abort: got v=%b code=%h brk=%b ext_bit=%b exp 1 01c 0 0",
                     evt_valid, evt_code, evt_break, key_down[9'h11C]);
        end
        do_flush();
        send(8'hE0);
        repeat (60) @(negedge clk);
        send(8'h1C);
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 9'h01C || key_down[9'h11C] !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort: got v=%b code=%h ext_bit=%b exp 1 01c 0",
                     evt_valid, evt_code, key_down[9'h11C]);
        end
        do_flush();
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        checks++;
        if (evt_valid !== 1'b0 || key_down !== '0 || down_count !== 4'd0) begin
            errors++;
            $display("FAIL pause_skip: got v=%b map_nz=%b cnt=%0d exp 0 0 0",
                     evt_valid, |key_down, down_count);
        end
        send(8'h1C);
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 9'h01C || down_count !== 4'd1) begin
            errors++;
            $display("FAIL pause_resume: got v=%b code=%h cnt=%0d exp 1 01c 1",
                     evt_valid, evt_code, down_count);
        end
        send(8'hAA);
        checks++;
        if (key_down !== '0 || down_count !== 4'd0 || evt_valid !== 1'b1) begin
            errors++;
            $display("FAIL aa_clear: got map_nz=%b cnt=%0d v=%b exp 0 0 1",
                     |key_down, down_count, evt_valid);
        end
        do_flush();
    endtask

    initial begin
        test_reset();
        test_make();
        test_ext();
        test_repeat();
        test_rollover();
        test_overflow();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
